// File: rtl/gray_pkg.sv
// Shared types and helpers for the gray-code receive path.
package gray_pkg;

    localparam int GRAY_W = 4;

    typedef enum logic {
        INIT  = 1'b0,
        TRACK = 1'b1
    } state_e;

    // Evaluated at 32 bits; zero upper bits leave the low bits unaffected.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = g[i] ^ b[i+1];
        end
        return b;
    endfunction

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < 32; i++) begin
            c += 32'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/gray_sync2.sv
// Two-flop synchronizer for a gray-coded bus from a foreign clock domain.
module gray_sync2 #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] q_o
);

    logic [N-1:0] s1_q;
    logic [N-1:0] s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/gray_rx_decoder.sv
// Tracks a synchronized gray count, reporting binary value, step delta,
// change pulse and a sticky error on illegal multi-bit transitions.
module gray_rx_decoder
    import gray_pkg::*;
#(
    parameter int N = GRAY_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] gray_in,
    input  logic         en,
    input  logic         err_clr,
    output logic [N-1:0] bin_out,
    output logic [N-1:0] delta,
    output logic         chg,
    output logic         err
);

    logic [N-1:0] s2;
    logic [N-1:0] bin_d;
    int unsigned  flips;

    state_e       state_q;
    logic [N-1:0] g_prev_q;
    logic [N-1:0] bin_q;
    logic [N-1:0] delta_q;
    logic         chg_q;
    logic         err_q;

    gray_sync2 #(.N(N)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (gray_in),
        .q_o   (s2)
    );

    always_comb begin
        bin_d = N'(gray2bin(32'(s2)));
        flips = popcount(32'(s2 ^ g_prev_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= INIT;
            g_prev_q <= '0;
            bin_q    <= '0;
            delta_q  <= '0;
            chg_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            chg_q <= 1'b0;
            if (err_clr) err_q <= 1'b0;
            if (!en) begin
                state_q <= INIT;
            end else begin
                case (state_q)
                    INIT: begin
                        g_prev_q <= s2;
                        bin_q    <= bin_d;
                        delta_q  <= '0;
                        state_q  <= TRACK;
                    end
                    TRACK: begin
                        unique case (1'b1)
                            (flips == 0): begin
                            end
                            (flips == 1): begin
                                g_prev_q <= s2;
                                bin_q    <= bin_d;
                                delta_q  <= bin_d - bin_q;
                                chg_q    <= 1'b1;
                            end
                            (flips > 1): begin
                                // Setting here overrides a same-cycle clear.
                                err_q    <= 1'b1;
                                g_prev_q <= s2;
                                bin_q    <= bin_d;
                                delta_q  <= '0;
                            end
                        endcase
                    end
                    default: state_q <= INIT;
                endcase
            end
        end
    end

    assign bin_out = bin_q;
    assign delta   = delta_q;
    assign chg     = chg_q;
    assign err     = err_q;

endmodule

// File: doc/gray_rx_decoder.md
GRAY_RX_DECODER -- requirements
Module: gray_rx_decoder

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the gray/binary word width (minimum 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port gray_in, input, N bits: gray-coded count from an unrelated source, possibly asynchronous to clk.
REQ-005 The block SHALL have port en, input, 1 bit: tracking enable.
REQ-006 The block SHALL have port err_clr, input, 1 bit: clears the sticky error flag.
REQ-007 The block SHALL have port bin_out, output, N bits: registered binary value of the last accepted gray sample.
REQ-008 The block SHALL have port delta, output, N bits: registered modulo-2^N difference, new minus previous accepted binary.
REQ-009 The block SHALL have port chg, output, 1 bit: one-cycle pulse on each accepted single-step change.
REQ-010 The block SHALL have port err, output, 1 bit: sticky flag set on an illegal multi-bit gray transition.

Function
REQ-011 The block SHALL pass gray_in through a two-flop synchronizer (s1, then s2) every cycle, regardless of en.
REQ-012 The block SHALL implement FSM states INIT and TRACK; reset and en=0 SHALL force INIT.
REQ-013 In INIT with en=1, the block SHALL load g_prev from s2 and bin_out from the binary of s2, with chg=0, delta=0 and err unchanged, then go to TRACK.
REQ-014 In TRACK, when s2 equals g_prev, the block SHALL hold g_prev and bin_out, with chg=0 and delta unchanged.
REQ-015 In TRACK, when s2 differs from g_prev in exactly one bit, the block SHALL set g_prev to s2, bin_out to binary(s2), delta to binary(s2) minus the old bin_out modulo 2^N, and chg=1 for one cycle.
REQ-016 In TRACK, when s2 differs from g_prev in two or more bits, the block SHALL set err=1, resync g_prev and bin_out to s2, and drive delta=0 and chg=0.
REQ-017 Gray-to-binary conversion SHALL be: b[N-1]=g[N-1]; b[i]=g[i] XOR b[i+1].
REQ-018 Delta SHALL wrap with no saturation: 15 to 0 gives delta=1, and 0 to 15 gives delta=15 (N=4).
REQ-019 Latency from a gray_in change to updated bin_out/chg SHALL be 3 clk edges (s1, s2, output register).
REQ-020 err_clr=1 SHALL clear err on the next edge; if err_clr and a new error occur in the same cycle, set SHALL win.
REQ-021 While en=0, bin_out, delta and err SHALL hold and chg SHALL be 0; re-enable SHALL re-prime via INIT without flagging err.

Reset
REQ-022 rst_n low SHALL immediately force s1, s2, g_prev, bin_out, delta, chg and err to 0 and the state to INIT, including mid-operation.
REQ-023 Reset release SHALL need no synchronous recovery beyond the normal INIT priming cycle.

Structure
REQ-024 Package gray_pkg SHALL hold the default width constant, the state enum (INIT, TRACK), the gray-to-binary function and the popcount function.
REQ-025 The synchronizer SHALL be a separate sub-module gray_sync2 (N-bit, two-flop, async active-low reset); all other logic SHALL be in gray_rx_decoder.

Verification
REQ-026 Scenario 1: reset, en=1, gray_in=0000 held -> TRACK after priming, bin_out=0000, chg never asserted, err=0.
REQ-027 Scenario 2: gray_in 0000->0001->0011 -> bin_out 0001 then 0010, delta=0001 each time, one chg pulse per step, each 3 edges after the change.
REQ-028 Scenario 3: wrap at N=4, gray 1000 (bin 15)->0000 -> delta=0001; 0000->1000 -> delta=1111.
REQ-029 Scenario 4: gray 0000->0110 -> err=1, chg=0, bin_out=0100, delta=0; then err_clr pulse -> err=0; err_clr coincident with a new jump -> err stays 1.
REQ-030 Scenario 5: rst_n asserted mid-stream between edges -> all outputs 0 without waiting for clk; after release, INIT re-priming occurs.
REQ-031 Scenario 6: en=0 while gray moves 0001->0111 -> bin_out held at 0001; en=1 -> silent re-prime to bin_out=0101, chg=0, err=0.
